// File: rtl/operand_loader.sv
// Two-operand loader: a debounced KEY[1] press captures SW into X, then into Y.
// A completed X/Y pair raises VALID; the next press starts a new pair with X.
module operand_loader #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic       CLOCK_50,
   input  logic [1:0] KEY,
   input  logic [7:0] SW,
   output logic [7:0] X,
   output logic [7:0] Y,
   output logic       VALID,
   output logic [1:0] STATE
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_X    = 2'b00,
      S_Y    = 2'b01,
      S_DONE = 2'b10,
      S_BAD  = 2'b11
   } state_t;

   logic             w_rst_n;
   logic             w_mismatch;
   logic             w_accept;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   state_t           r_state;
   logic [7:0]       r_x;
   logic [7:0]       r_y;
   logic             r_valid;

   assign w_rst_n    = KEY[0];
   assign w_mismatch = (r_sync2 != r_stable);
   assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

   // Synchronizer and debouncer; idle level of the button is high.
   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sync1  <= 1'b1;
         r_sync2  <= 1'b1;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync1 <= KEY[1];
         r_sync2 <= r_sync1;
         if (!w_mismatch) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Only a falling stable level is a press; releases are silent.
         r_press <= w_accept & ~r_sync2;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= S_X;
         r_x     <= 8'h00;
         r_y     <= 8'h00;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            S_X: begin
               if (r_press) begin
                  r_x     <= SW;
                  r_state <= S_Y;
               end
            end
            S_Y: begin
               if (r_press) begin
                  r_y     <= SW;
                  r_valid <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Y keeps the old operand; VALID low marks the pair stale.
               if (r_press) begin
                  r_x     <= SW;
                  r_valid <= 1'b0;
                  r_state <= S_Y;
               end
            end
            default: begin
               r_state <= S_X;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign X     = r_x;
   assign Y     = r_y;
   assign VALID = r_valid;
   assign STATE = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader with DEBOUNCE_CYCLES=4: table vectors, corner
// sequences and random button activity against a behavioural model.
module tb_operand_loader;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic [1:0] key;
   logic [7:0] sw;
   logic [7:0] x_o, y_o;
   logic       valid_o;
   logic [1:0] state_o;

   int n_tests = 0;
   int n_fail  = 0;

   operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
      .CLOCK_50(clk),
      .KEY     (key),
      .SW      (sw),
      .X       (x_o),
      .Y       (y_o),
      .VALID   (valid_o),
      .STATE   (state_o)
   );

   always #5 clk = ~clk;

   // Model: button samples reach the debouncer two edges late; a new level is
   // accepted after D consecutive differing samples; a press loads next edge.
   bit         m_q[$];
   bit         m_stable;
   int         m_run;
   bit         m_press;
   int         m_phase;
   logic [7:0] m_x, m_y;
   bit         m_valid;

   task automatic model_reset();
      m_q = {1'b1, 1'b1};
      m_stable = 1'b1;
      m_run = 0;
      m_press = 1'b0;
      m_phase = 0;
      m_x = 8'h00;
      m_y = 8'h00;
      m_valid = 1'b0;
   endtask

   task automatic model_edge();
      bit samp;
      bit nxt;
      if (m_press) begin
         if (m_phase == 0) begin
            m_x = sw; m_phase = 1;
         end else if (m_phase == 1) begin
            m_y = sw; m_valid = 1'b1; m_phase = 2;
         end else begin
            m_x = sw; m_valid = 1'b0; m_phase = 1;
         end
      end
      samp = m_q.pop_front();
      m_q.push_back(key[1]);
      nxt = 1'b0;
      if (samp != m_stable) begin
         m_run = m_run + 1;
         if (m_run == D) begin
            m_stable = samp;
            m_run = 0;
            nxt = (samp == 1'b0);
         end
      end else begin
         m_run = 0;
      end
      m_press = nxt;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".X"}, x_o, m_x);
      check({tag, ".Y"}, y_o, m_y);
      check({tag, ".VALID"}, {7'd0, valid_o}, {7'd0, m_valid});
      check({tag, ".STATE"}, {6'd0, state_o}, 8'(m_phase));
   endtask

   task automatic check_const(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                              input logic ev, input logic [1:0] es);
      check({tag, ".X"}, x_o, ex);
      check({tag, ".Y"}, y_o, ey);
      check({tag, ".VALID"}, {7'd0, valid_o}, {7'd0, ev});
      check({tag, ".STATE"}, {6'd0, state_o}, {6'd0, es});
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      if (key[0] == 1'b0) model_reset();
      else model_edge();
      #1;
      check_model(tag);
   endtask

   typedef struct {
      logic [7:0] sw;
      int         low;
      int         high;
      logic [7:0] sw_late;
      logic [7:0] ex;
      logic [7:0] ey;
      logic       ev;
      logic [1:0] es;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{8'h3C, 12, 8, 8'h3C, 8'h3C, 8'h00, 1'b0, 2'b01};
      vecs[1] = '{8'hA5,  8, 8, 8'h5A, 8'h3C, 8'hA5, 1'b1, 2'b10};
      vecs[2] = '{8'hFF,  3, 3, 8'hFF, 8'h3C, 8'hA5, 1'b1, 2'b10};
      vecs[3] = '{8'hEE,  3, 2, 8'hEE, 8'h3C, 8'hA5, 1'b1, 2'b10};
      vecs[4] = '{8'h77,  1, 1, 8'h77, 8'h3C, 8'hA5, 1'b1, 2'b10};
      vecs[5] = '{8'h11,  8, 8, 8'h99, 8'h11, 8'hA5, 1'b0, 2'b01};
      vecs[6] = '{8'h22, 50, 8, 8'h44, 8'h11, 8'h22, 1'b1, 2'b10};
      vecs[7] = '{8'h33, 50, 8, 8'h55, 8'h33, 8'h22, 1'b0, 2'b01};

      key = 2'b10;
      sw  = 8'h00;
      model_reset();
      #2;
      check_const("reset", 8'h00, 8'h00, 1'b0, 2'b00);
      @(negedge clk);
      key[0] = 1'b1;
      repeat (3) tick("idle");

      for (int i = 0; i < 8; i++) begin
         sw = vecs[i].sw;
         key[1] = 1'b0;
         for (int c = 0; c < vecs[i].low; c++) tick($sformatf("vec%0d.low", i));
         sw = vecs[i].sw_late;
         key[1] = 1'b1;
         for (int c = 0; c < vecs[i].high; c++) tick($sformatf("vec%0d.high", i));
         check_const($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ev, vecs[i].es);
      end

      // Button already low across reset release: load lands on edge 7 exactly.
      key[0] = 1'b0;
      key[1] = 1'b0;
      sw = 8'h5A;
      #1;
      model_reset();
      check_const("rst_lowkey", 8'h00, 8'h00, 1'b0, 2'b00);
      @(negedge clk);
      key[0] = 1'b1;
      repeat (6) tick("lat");
      check_const("lat.edge6", 8'h00, 8'h00, 1'b0, 2'b00);
      tick("lat");
      check_const("lat.edge7", 8'h5A, 8'h00, 1'b0, 2'b01);

      // Reset in the middle of a debounce while in S_Y discards the press.
      key[1] = 1'b1;
      repeat (8) tick("rel");
      sw = 8'hC3;
      key[1] = 1'b0;
      repeat (4) tick("mid");
      key[0] = 1'b0;
      #1;
      model_reset();
      check_const("midrst", 8'h00, 8'h00, 1'b0, 2'b00);
      tick("inrst");
      @(negedge clk);
      key[0] = 1'b1;
      repeat (6) tick("post");
      check_const("post.edge6", 8'h00, 8'h00, 1'b0, 2'b00);
      tick("post");
      check_const("post.edge7", 8'hC3, 8'h00, 1'b0, 2'b01);

      // Random bouncing with random operand changes.
      for (int seg = 0; seg < 400; seg++) begin
         int len;
         key[1] = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 8);
         for (int c = 0; c < len; c++) begin
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            tick("rand");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000, number of consecutive clocks a new button level must hold before it is accepted (20 ms at 50 MHz); SHALL be >= 1.
REQ-002 CLOCK_50  input  1  sole clock; all state SHALL change on its rising edge only.
REQ-003 KEY[0]  input  1  reset; asynchronous, active-low.
REQ-004 KEY[1]  input  1  load pushbutton; active-low, asynchronous to CLOCK_50, bouncy.
REQ-005 SW  input  8  operand data source.
REQ-006 X  output  8  first operand, registered; drives the mux X input.
REQ-007 Y  output  8  second operand, registered; drives the mux Y input.
REQ-008 VALID  output  1  high when X and Y hold a complete, matched pair.
REQ-009 STATE  output  2  FSM state encoding: S_X=00, S_Y=01, S_DONE=10; 11 is unused.

Function
REQ-010 KEY[1] SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Debounce: a counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, SHALL increment on each edge where the synchronized level differs from the stable level.
REQ-012 The counter SHALL clear on any edge where the synchronized level equals the stable level.
REQ-013 On the edge where a mismatch occurs with counter == DEBOUNCE_CYCLES-1, the stable level SHALL take the synchronized value and the counter SHALL clear.
REQ-014 A press event SHALL be a one-cycle registered pulse, asserted on the edge where the stable level goes 1->0; a stable 0->1 transition SHALL produce no event.
REQ-015 Latency: with KEY[1] held low from before edge 1, the press pulse SHALL be high after edge 2+DEBOUNCE_CYCLES, and the load SHALL occur at edge 3+DEBOUNCE_CYCLES.
REQ-016 A button held low indefinitely SHALL yield exactly one press event; the next event SHALL require a debounced release followed by a debounced press.
REQ-017 A low glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event.
REQ-018 FSM, S_X + press: X<=SW, go to S_Y.
REQ-019 FSM, S_Y + press: Y<=SW, VALID<=1, go to S_DONE.
REQ-020 FSM, S_DONE + press: X<=SW, VALID<=0, go to S_Y (a new pair begins).
REQ-021 With no press, the FSM SHALL hold state, X, Y and VALID unchanged.
REQ-022 SW SHALL be sampled only on the load edge; changes to SW at any other time SHALL have no effect.
REQ-023 Y SHALL retain its previous value while a new X is being loaded; VALID=0 flags the pair as stale.
REQ-024 State 11, if ever reached, SHALL return to S_X on the next edge with VALID=0.
REQ-025 X, Y, VALID and STATE SHALL be driven directly from flops; no combinational path from any input to any output.

Reset
REQ-026 While KEY[0]=0, the block SHALL immediately force X=0, Y=0, VALID=0, STATE=S_X.
REQ-027 While KEY[0]=0, synchronizer flops SHALL be forced to 1, stable level to 1, debounce counter to 0, press pulse to 0.
REQ-028 Reset asserted mid-debounce or mid-pair SHALL discard all partial progress.
REQ-029 After KEY[0] releases, the first load SHALL require a full debounced press, even if KEY[1] is already low.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, SW=0x3C, hold KEY[1] low 12 cycles -> X=0x3C at edge 7, STATE=01, VALID=0, Y=0x00.
REQ-031 Release, debounce, SW=0xA5, press again -> Y=0xA5, VALID=1, STATE=10; X stays 0x3C.
REQ-032 KEY[1] low for 3 cycles then high, repeated with bounce -> no event, outputs unchanged.
REQ-033 In S_DONE, SW=0x11, press -> X=0x11, VALID=0, STATE=01, Y=0xA5.
REQ-034 KEY[1] held low 50 cycles -> exactly one load.
REQ-035 KEY[0] pulsed low mid-debounce in S_Y -> all outputs return to reset values asynchronously; the pending press is lost.
